// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment driver: shadow-buffered hex digits are scanned
// one slot per COUNT_MAX cycles, with optional leading-zero blanking and polarity flip.

module seven_seg_digit #(
  parameter int LANE  = 0,
  parameter int BLANK = 0
) (
  input  logic [3:0] nib,
  input  logic       en,
  input  logic       tail_zero,
  output logic       lit,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b0000000;
    case (nib)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1110011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      4'hF: seg = 7'b1000111;
      default: seg = 7'b0000000;
    endcase
  end

  // Digit 0 always shows something, even when the whole value is zero.
  assign lit = en && !((BLANK != 0) && (LANE != 0) && tail_zero);
endmodule

module seven_seg_scan #(
  parameter int N_DIGITS      = 4,
  parameter int COUNT_MAX     = 100000,
  parameter int ACTIVE_LOW    = 1,
  parameter int BLANK_LEADING = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  load,
  output logic [6:0]            segs,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   anodes,
  output logic                  scan_tick
);
  localparam int CW = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNT_MAX - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic          POL      = (ACTIVE_LOW != 0);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic                    tick;
  logic [4*N_DIGITS-1:0]   sh_value;
  logic [N_DIGITS-1:0]     sh_dp;
  logic [N_DIGITS-1:0]     sh_en;

  logic [N_DIGITS-1:0][6:0] lane_seg;
  logic [N_DIGITS-1:0]      lane_lit;
  logic [N_DIGITS-1:0]      tail_zero;

  logic                cur_lit;
  logic [6:0]          cur_seg;
  logic                cur_dp;
  logic [N_DIGITS-1:0] cur_an;

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      idx       <= '0;
      scan_tick <= 1'b0;
    end else begin
      cnt       <= tick ? '0 : cnt + CW'(1);
      scan_tick <= tick;
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_value <= '0;
      sh_dp    <= '0;
      sh_en    <= '0;
    end else if (load) begin
      sh_value <= value;
      sh_dp    <= dp_in;
      sh_en    <= digit_en;
    end
  end

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_lane
    // Leading-zero test looks at this nibble and every more-significant one.
    assign tail_zero[i] = (sh_value[4*N_DIGITS-1:4*i] == '0);

    seven_seg_digit #(
      .LANE (i),
      .BLANK(BLANK_LEADING)
    ) u_digit (
      .nib      (sh_value[4*i +: 4]),
      .en       (sh_en[i]),
      .tail_zero(tail_zero[i]),
      .lit      (lane_lit[i]),
      .seg      (lane_seg[i])
    );
  end

  // Selector loop rather than a direct index so non-power-of-two widths stay clean.
  always_comb begin
    cur_lit = 1'b0;
    cur_seg = 7'b0000000;
    cur_dp  = 1'b0;
    cur_an  = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_lit   = lane_lit[i];
        cur_seg   = lane_seg[i];
        cur_dp    = sh_dp[i];
        cur_an[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      segs   <= {7{POL}};
      dp     <= POL;
      anodes <= {N_DIGITS{POL}};
    end else begin
      segs   <= (cur_lit ? cur_seg : 7'b0000000) ^ {7{POL}};
      dp     <= (cur_lit & cur_dp) ^ POL;
      anodes <= (cur_lit ? cur_an : '0) ^ {N_DIGITS{POL}};
    end
  end
endmodule

// File: tb/tb_seven_seg_scan.sv
// Drives five differently configured scanners from shared inputs and checks each
// against an arithmetic model of slot position and shadow contents.

module tb_seven_seg_scan;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [31:0] value = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  digit_en = '0;

  logic [6:0] s0, s1, s2, s3, s4;
  logic       d0, d1, d2, d3, d4;
  logic       t0, t1, t2, t3, t4;
  logic [3:0] a0, a1, a2;
  logic [0:0] a3;
  logic [2:0] a4;

  int total = 0;
  int bad   = 0;
  int e     = 0;
  logic [31:0] m_val = '0;
  logic [7:0]  m_dp  = '0;
  logic [7:0]  m_en  = '0;

  logic [6:0] dec [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  always #5 clk = ~clk;

  seven_seg_scan #(.N_DIGITS(4), .COUNT_MAX(4), .ACTIVE_LOW(0), .BLANK_LEADING(0)) u0 (
    .clk(clk), .reset(reset), .value(value[15:0]), .dp_in(dp_in[3:0]),
    .digit_en(digit_en[3:0]), .load(load), .segs(s0), .dp(d0), .anodes(a0), .scan_tick(t0));
  seven_seg_scan #(.N_DIGITS(4), .COUNT_MAX(4), .ACTIVE_LOW(0), .BLANK_LEADING(1)) u1 (
    .clk(clk), .reset(reset), .value(value[15:0]), .dp_in(dp_in[3:0]),
    .digit_en(digit_en[3:0]), .load(load), .segs(s1), .dp(d1), .anodes(a1), .scan_tick(t1));
  seven_seg_scan #(.N_DIGITS(4), .COUNT_MAX(4), .ACTIVE_LOW(1), .BLANK_LEADING(0)) u2 (
    .clk(clk), .reset(reset), .value(value[15:0]), .dp_in(dp_in[3:0]),
    .digit_en(digit_en[3:0]), .load(load), .segs(s2), .dp(d2), .anodes(a2), .scan_tick(t2));
  seven_seg_scan #(.N_DIGITS(1), .COUNT_MAX(3), .ACTIVE_LOW(0), .BLANK_LEADING(0)) u3 (
    .clk(clk), .reset(reset), .value(value[3:0]), .dp_in(dp_in[0:0]),
    .digit_en(digit_en[0:0]), .load(load), .segs(s3), .dp(d3), .anodes(a3), .scan_tick(t3));
  seven_seg_scan #(.N_DIGITS(3), .COUNT_MAX(2), .ACTIVE_LOW(1), .BLANK_LEADING(1)) u4 (
    .clk(clk), .reset(reset), .value(value[11:0]), .dp_in(dp_in[2:0]),
    .digit_en(digit_en[2:0]), .load(load), .segs(s4), .dp(d4), .anodes(a4), .scan_tick(t4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at edge %0d: got=%0h want=%0h", tag, e, obs, exp);
    end
  endtask

  // Expected outputs come from slot arithmetic: after edge e (counted from the
  // reset edge) the display shows digit floor((e-1)/cm) mod n from the shadow
  // that existed before edge e.
  task automatic chk_inst(input string nm, input int n, input int cm, input int al,
                          input int bl, input bit rst, input logic [7:0] an,
                          input logic [6:0] sg, input logic dpo, input logic tk);
    logic [6:0] es;
    logic [7:0] ea;
    logic       ed, et, lit;
    longint     full, tail;
    int         idx;
    if (rst) begin
      es = 7'b0; ea = 8'b0; ed = 1'b0; et = 1'b0;
    end else begin
      idx  = ((e - 1) / cm) % n;
      full = longint'(m_val) & ((64'd1 << (4 * n)) - 1);
      tail = full >> (4 * idx);
      lit  = m_en[idx] && !(bl != 0 && idx > 0 && tail == 0);
      es   = lit ? dec[tail & 15] : 7'b0;
      ea   = lit ? 8'(1 << idx) : 8'b0;
      ed   = lit ? m_dp[idx] : 1'b0;
      et   = (e % cm) == 0;
    end
    if (al != 0) begin
      es = es ^ 7'h7f;
      ea = ea ^ 8'((1 << n) - 1);
      ed = ~ed;
    end
    chk({nm, ".segs"}, 32'(sg), 32'(es));
    chk({nm, ".anodes"}, 32'(an), 32'(ea));
    chk({nm, ".dp"}, 32'(dpo), 32'(ed));
    chk({nm, ".scan_tick"}, 32'(tk), 32'(et));
  endtask

  task automatic step(input bit rst, input bit ld);
    reset = rst;
    load  = ld;
    @(posedge clk);
    #1;
    if (!rst) e++;
    chk_inst("u0", 4, 4, 0, 0, rst, 8'(a0), s0, d0, t0);
    chk_inst("u1", 4, 4, 0, 1, rst, 8'(a1), s1, d1, t1);
    chk_inst("u2", 4, 4, 1, 0, rst, 8'(a2), s2, d2, t2);
    chk_inst("u3", 1, 3, 0, 0, rst, 8'(a3), s3, d3, t3);
    chk_inst("u4", 3, 2, 1, 1, rst, 8'(a4), s4, d4, t4);
    if (rst) begin
      e = 0; m_val = '0; m_dp = '0; m_en = '0;
    end else if (ld) begin
      m_val = value; m_dp = dp_in; m_en = digit_en;
    end
    load = 1'b0;
  endtask

  initial begin
    step(1, 0);
    step(1, 0);

    // Basic scan of 12AF with every digit enabled.
    value = 32'h12AF; digit_en = 8'hFF; dp_in = 8'h00;
    step(0, 1);
    for (int i = 0; i < 20; i++) step(0, 0);

    // Input changes without load must not reach the display.
    value = 32'h3333; dp_in = 8'hFF;
    for (int i = 0; i < 3; i++) step(0, 0);

    // Load on the tick edge of the 4-cycle instances.
    for (int k = 0; k < 8 && ((e + 1) % 4 != 0); k++) step(0, 0);
    value = 32'h4567; dp_in = 8'h05;
    step(0, 1);
    for (int i = 0; i < 8; i++) step(0, 0);

    // Leading-zero patterns.
    value = 32'h0050; dp_in = 8'h00;
    step(0, 1);
    for (int i = 0; i < 16; i++) step(0, 0);
    value = 32'h0;
    step(0, 1);
    for (int i = 0; i < 16; i++) step(0, 0);

    // Digit 0 shows 8 with its decimal point.
    value = 32'h0008; dp_in = 8'h01;
    step(0, 1);
    for (int i = 0; i < 8; i++) step(0, 0);

    // Partial enables.
    value = 32'h9C0B; digit_en = 8'h05; dp_in = 8'h0A;
    step(0, 1);
    for (int i = 0; i < 16; i++) step(0, 0);

    // Reset while the 4-digit instances are in the digit 2 slot; a load is ignored.
    digit_en = 8'hFF; value = 32'hDEAD;
    step(0, 1);
    for (int k = 0; k < 20 && (((e - 1) / 4) % 4 != 2); k++) step(0, 0);
    step(0, 0);
    step(1, 1);
    for (int i = 0; i < 10; i++) step(0, 0);

    for (int i = 0; i < 400; i++) begin
      value = $urandom;
      if ($urandom_range(0, 1) == 1) value = value >> (4 * $urandom_range(1, 7));
      dp_in    = 8'($urandom);
      digit_en = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter N_DIGITS, default 4, meaning number of multiplexed digits (legal 1..8).
REQ-002 Parameter COUNT_MAX, default 100000, meaning clk cycles per digit slot (legal >= 2).
REQ-003 Parameter ACTIVE_LOW, default 1, meaning 1 inverts segs, dp and anodes for negative-polarity boards; 0 gives positive polarity.
REQ-004 Parameter BLANK_LEADING, default 0, meaning 1 enables leading-zero blanking.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 value  in  4*N_DIGITS  hex nibbles; nibble i = value[4i+3:4i] drives digit i (digit 0 rightmost).
REQ-008 dp_in  in  N_DIGITS  decimal-point request per digit.
REQ-009 digit_en  in  N_DIGITS  per-digit enable; 0 forces the digit dark.
REQ-010 load  in  1  one-cycle strobe capturing value, dp_in and digit_en into shadow registers.
REQ-011 segs  out  7  segment pattern, bit order abcdefg (segs[6]=a), registered.
REQ-012 dp  out  1  decimal point of active digit, registered.
REQ-013 anodes  out  N_DIGITS  digit select, one-hot (before polarity) or all inactive, registered.
REQ-014 scan_tick  out  1  one-cycle pulse when the digit index advances, registered.

Function
REQ-015 Refresh counter SHALL count 0..COUNT_MAX-1 and wrap to 0; tick condition = counter == COUNT_MAX-1.
REQ-016 On tick, digit index SHALL advance idx -> idx+1, wrapping N_DIGITS-1 -> 0; with N_DIGITS=1 idx stays 0.
REQ-017 scan_tick SHALL be 1 in the cycle immediately after the tick condition, else 0.
REQ-018 When load=1, shadow registers SHALL capture value, dp_in, digit_en at that edge; otherwise hold; outputs SHALL use shadow contents only (no tearing mid-slot).
REQ-019 Outputs SHALL be registered: segs/dp/anodes reflect idx and shadow contents as of the previous edge (one-cycle latency).
REQ-020 Positive-polarity decode SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-021 Digit idx is dark when digit_en[idx]=0, or when BLANK_LEADING=1, idx>0 and nibbles idx..N_DIGITS-1 are all zero; digit 0 never blanked by leading-zero rule.
REQ-022 Dark digit: anodes all inactive, segs all off, dp off.
REQ-023 Lit digit: anode idx active only; segs = decode(nibble idx); dp = shadow dp_in[idx].
REQ-024 ACTIVE_LOW=1 SHALL invert segs, dp and anodes after all logic above; scan_tick never inverted.
REQ-025 load coincident with tick SHALL apply: new idx is displayed with newly loaded data one cycle later.

Reset
REQ-026 reset=1 at an edge SHALL clear counter, idx, shadow value/dp/en to 0, scan_tick to 0, and drive segs, dp, anodes to the inactive level (all 1 when ACTIVE_LOW=1, all 0 otherwise).
REQ-027 reset SHALL take priority over load and tick; reset mid-slot restarts scanning at digit 0 with counter 0.
REQ-028 After reset release, first tick SHALL occur COUNT_MAX cycles later.

Verification (N_DIGITS=4, COUNT_MAX=4, ACTIVE_LOW=0 unless stated)
REQ-029 Reset 2 cycles, load value=16'h12AF, digit_en=4'hF -> anodes 0001,0010,0100,1000 each held 4 cycles; segs 1000111, 1110111, 1101101, 0110000 respectively; scan_tick pulses every 4 cycles.
REQ-030 BLANK_LEADING=1, load value=16'h0050, en=F -> digits 0,1 lit (1111110, 1011011); digits 2,3 anodes 0000, segs 0000000; value=0 -> only digit 0 lit showing 1111110.
REQ-031 ACTIVE_LOW=1, load value=16'h0008, dp_in=0001 -> during digit 0 anodes=1110, segs=0000000, dp=0; during reset all outputs 1.
REQ-032 Change value without load mid-slot -> segs unchanged; load at tick cycle -> next digit shows new nibble one cycle later.
REQ-033 Assert reset during digit 2 slot -> next cycle outputs inactive, shadow cleared; after release digit 0 displayed, first scan_tick 4 cycles after release.
REQ-034 N_DIGITS=1 -> anodes=1 continuously after load, scan_tick still pulses every COUNT_MAX cycles.
